// File: rtl/uart_rx_if.sv
// Serial-side and host-side signals of the oversampling UART receiver.
// master drives the line and frame options; slave is the receiver.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  RX_IN;
    logic                  Par_en;
    logic                  Par_typ;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    modport master (
        output RX_IN, Par_en, Par_typ,
        input  P_DATA, data_valid, par_err, stp_err, busy
    );

    modport slave (
        input  RX_IN, Par_en, Par_typ,
        output P_DATA, data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// Oversampling UART receiver: start qualify, 3-sample majority vote,
// LSB-first deserialize, optional parity, stop check, one-cycle results.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  rx
);
    localparam int EW = $clog2(PRESCALE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [EW-1:0] T_M1   = EW'(PRESCALE/2 - 1);
    localparam logic [EW-1:0] T_M    = EW'(PRESCALE/2);
    localparam logic [EW-1:0] T_DEC  = EW'(PRESCALE/2 + 1);
    localparam logic [EW-1:0] T_LAST = EW'(PRESCALE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        STR,
        DATA,
        PAR,
        STP
    } state_t;

    state_t                state;
    logic                  sync1;
    logic                  rx_s;
    logic                  rx_s_d;
    logic [EW-1:0]         edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic                  smp0;
    logic                  smp1;
    logic                  pen_l;
    logic                  ptyp_l;
    logic                  par_flag;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  dv_q;
    logic                  pe_q;
    logic                  se_q;
    logic                  maj;
    logic                  is_dec;
    logic                  is_last;

    // Third sample is the live rx_s at the decision tick.
    assign maj = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
    assign is_dec  = (edge_cnt == T_DEC);
    assign is_last = (edge_cnt == T_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            sync1  <= rx.RX_IN;
            rx_s   <= sync1;
            rx_s_d <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            smp0     <= 1'b0;
            smp1     <= 1'b0;
            pen_l    <= 1'b0;
            ptyp_l   <= 1'b0;
            par_flag <= 1'b0;
            shreg    <= '0;
            p_data   <= '0;
            dv_q     <= 1'b0;
            pe_q     <= 1'b0;
            se_q     <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            pe_q <= 1'b0;
            se_q <= 1'b0;
            if (state != IDLE) begin
                edge_cnt <= is_last ? '0 : edge_cnt + 1'b1;
                if (edge_cnt == T_M1) smp0 <= rx_s;
                if (edge_cnt == T_M)  smp1 <= rx_s;
            end
            unique case (state)
                IDLE: begin
                    if (rx_s_d && !rx_s) begin
                        state    <= STR;
                        edge_cnt <= EW'(1);
                        pen_l    <= rx.Par_en;
                        ptyp_l   <= rx.Par_typ;
                        shreg    <= '0;
                        par_flag <= 1'b0;
                    end
                end
                STR: begin
                    if (is_dec && maj) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end else if (is_last) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (is_dec) begin
                        shreg <= (shreg >> 1)
                            | (DATA_WIDTH'(maj) << (DATA_WIDTH - 1));
                    end
                    if (is_last) begin
                        if (bit_cnt == B_LAST) begin
                            state <= pen_l ? PAR : STP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (is_dec) par_flag <= maj ^ (^shreg) ^ ptyp_l;
                    if (is_last) state <= STP;
                end
                STP: begin
                    // Rest of the stop bit is treated as idle line.
                    if (is_dec) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                        bit_cnt  <= '0;
                        se_q     <= ~maj;
                        pe_q     <= par_flag;
                        if (maj && !par_flag) begin
                            dv_q   <= 1'b1;
                            p_data <= shreg;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx.P_DATA     = p_data;
    assign rx.data_valid = dv_q;
    assign rx.par_err    = pe_q;
    assign rx.stp_err    = se_q;
    assign rx.busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: frame table plus corner sequences.
// Pulse timing is measured in cycles from the RX_IN start drive.
module tb_uart_rx_fsm;
    localparam int P = 8;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    uart_rx_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_fsm #(
        .DATA_WIDTH(8),
        .PRESCALE  (P)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int dv_n, pe_n, se_n, busy_n, last_pulse;
    int dv_cyc[$];
    logic [7:0] dv_dat[$];

    always @(negedge clk) begin
        if (bus.data_valid) begin
            dv_n++;
            dv_cyc.push_back(cyc);
            dv_dat.push_back(bus.P_DATA);
        end
        if (bus.par_err) pe_n++;
        if (bus.stp_err) se_n++;
        if (bus.data_valid || bus.par_err || bus.stp_err)
            last_pulse = cyc;
        if (bus.busy) busy_n++;
    end

    typedef struct {
        logic [7:0] d;
        bit         pen;
        bit         ptyp;
        bit         pbit;
        bit         stop;
        int         dv;
        int         pe;
        int         se;
        logic [7:0] pd;
        int         lat;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic clr();
        dv_n = 0;
        pe_n = 0;
        se_n = 0;
        busy_n = 0;
        last_pulse = -1;
        dv_cyc.delete();
        dv_dat.delete();
    endtask

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame options flip after the start bit; the DUT must use latched ones.
    task automatic send_frame(
        input  logic [7:0] d,
        input  bit         pen,
        input  bit         ptyp,
        input  bit         pbit,
        input  bit         stop,
        input  int         glitch,
        input  int         ncyc,
        output int         k
    );
        logic [10:0] fb;
        int nb;
        int total;
        fb = '1;
        fb[0] = 1'b0;
        for (int b = 0; b < 8; b++) fb[b+1] = d[b];
        if (pen) fb[9] = pbit;
        fb[9 + int'(pen)] = stop;
        nb = 10 + int'(pen);
        total = nb * P;
        if (ncyc >= 0 && ncyc < total) total = ncyc;
        k = cyc;
        for (int i = 0; i < total; i++) begin
            bus.RX_IN   = (i == glitch) ? 1'b0 : fb[i / P];
            bus.Par_en  = (i < P) ? pen : ~pen;
            bus.Par_typ = (i < P) ? ptyp : ~ptyp;
            @(posedge clk);
            #1;
        end
    endtask

    int k, k1, k2, k3;

    initial begin
        vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hA5, 78};
        vt[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'h3C, 86};
        vt[2] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1, 0, 8'h3C, 86};
        vt[3] = '{8'h96, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 0, 8'h96, 86};
        vt[4] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1, 0, 0, 8'h07, 86};
        vt[5] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'h07, 78};
        vt[6] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 1, 8'h07, 86};
        vt[7] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'h00, 78};
        vt[8] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 0, 8'h00, 86};

        bus.RX_IN = 1'b1;
        bus.Par_en = 1'b0;
        bus.Par_typ = 1'b0;
        rst = 1'b1;
        clr();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_pdata", int'(bus.P_DATA), 0);
        chk("rst_dv", int'(bus.data_valid), 0);
        chk("rst_pe", int'(bus.par_err), 0);
        chk("rst_se", int'(bus.stp_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            clr();
            idle(16);
            send_frame(vt[i].d, vt[i].pen, vt[i].ptyp, vt[i].pbit,
                       vt[i].stop, -1, -1, k);
            idle(24);
            @(negedge clk);
            chk($sformatf("v%0d_dv", i), dv_n, vt[i].dv);
            chk($sformatf("v%0d_pe", i), pe_n, vt[i].pe);
            chk($sformatf("v%0d_se", i), se_n, vt[i].se);
            chk($sformatf("v%0d_when", i), last_pulse - k, vt[i].lat + 2);
            chk($sformatf("v%0d_pdata", i), int'(bus.P_DATA),
                int'(vt[i].pd));
            chk($sformatf("v%0d_busy", i), busy_n, vt[i].lat - 1);
        end

        // Break: stop bit 0 and line held low for 20 bit times.
        clr();
        idle(16);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, k);
        busy_n = 0;
        bus.RX_IN = 1'b0;
        repeat (20 * P) begin
            @(posedge clk);
            #1;
        end
        chk("brk_se", se_n, 1);
        chk("brk_dv", dv_n, 0);
        chk("brk_busy_low", busy_n, 0);
        clr();
        idle(2 * P);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, k);
        idle(24);
        @(negedge clk);
        chk("brk_next_dv", dv_n, 1);
        chk("brk_next_pdata", int'(bus.P_DATA), 'h0F);
        chk("brk_next_se", se_n, 0);

        // Two-cycle low on the line: qualified away as a glitch.
        clr();
        idle(16);
        bus.RX_IN = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        idle(40);
        @(negedge clk);
        chk("glitch_busy", busy_n, 5);
        chk("glitch_pulses", dv_n + pe_n + se_n, 0);

        // One-cycle low at tick M of data bit 4 is voted out.
        clr();
        idle(16);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 5 * P + 4, -1, k);
        idle(24);
        @(negedge clk);
        chk("vote_dv", dv_n, 1);
        chk("vote_pdata", int'(bus.P_DATA), 'hFF);
        chk("vote_when", last_pulse - k, 80);

        // Back-to-back frames with one-bit stop.
        clr();
        idle(16);
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, k1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, k2);
        send_frame(8'h80, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, k3);
        idle(24);
        @(negedge clk);
        chk("b2b_count", dv_n, 3);
        if (dv_cyc.size() >= 3) begin
            chk("b2b_first", dv_cyc[0] - k1, 80);
            chk("b2b_gap1", dv_cyc[1] - dv_cyc[0], 80);
            chk("b2b_gap2", dv_cyc[2] - dv_cyc[1], 80);
            chk("b2b_d0", int'(dv_dat[0]), 'h01);
            chk("b2b_d1", int'(dv_dat[1]), 'hFF);
            chk("b2b_d2", int'(dv_dat[2]), 'h80);
        end

        // Reset during data bit 3 of 0x12 aborts the frame.
        clr();
        idle(16);
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1, 38, k);
        rst = 1'b1;
        bus.RX_IN = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_pdata", int'(bus.P_DATA), 0);
        chk("abort_outs", int'(bus.data_valid) + int'(bus.par_err)
            + int'(bus.stp_err), 0);
        idle(200);
        chk("abort_pulses", dv_n + pe_n + se_n, 0);
        clr();
        idle(16);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, k);
        idle(24);
        @(negedge clk);
        chk("post_rst_dv", dv_n, 1);
        chk("post_rst_pdata", int'(bus.P_DATA), 'h81);
        chk("post_rst_when", last_pulse - k, 80);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Oversampling UART receiver: the receive-side counterpart of the UART_TX path. It synchronizes the serial line, detects and qualifies the start bit, and samples each bit mid-period with a 3-sample majority vote. It deserializes data LSB first, checks optional even/odd parity and the stop bit, then presents the parallel byte with a one-cycle valid pulse. It sits between the RX pin and the host-side consumer, and runs on the same clock domain as the TX block at PRESCALE× the baud rate.

## Interface
- DATA_WIDTH, 8, data bits per frame (1..16)
- PRESCALE, 8, clk cycles per bit; even, ≥ 6
- clk  in  1  clock, PRESCALE × baud
- rst  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- RX_IN  in  1  asynchronous serial line, idle high
- Par_en  in  1  parity bit present when 1; latched at start detection
- Par_typ  in  1  0 = even, 1 = odd; latched at start detection
- P_DATA  out  DATA_WIDTH  last good received word, LSB = first data bit
- data_valid  out  1  one-cycle pulse, P_DATA updated
- par_err  out  1  one-cycle pulse, parity mismatch
- stp_err  out  1  one-cycle pulse, stop bit sampled 0
- busy  out  1  state ≠ IDLE (decode of state register)

## Operation
- RX_IN passes through a 2-flop synchronizer to give rx_s. Both flops reset to 1. rx_s_d is a registered copy of rx_s, reset to 1.
- States: IDLE, STR, DATA, PAR, STP. The tick counter edge_cnt runs 0..PRESCALE-1 within each bit, and bit_cnt counts data bits.
- IDLE
  - A falling edge (rx_s_d = 1, rx_s = 0) is tick 0 of the start bit: go to STR with edge_cnt ← 1, latch Par_en and Par_typ, clear the shift register.
  - A level-low line without a falling edge never starts a frame.
- Sampling
  - rx_s is captured at ticks M-1, M and M+1, with M = PRESCALE/2.
  - The majority of the three samples is the bit value, decided at tick M+1 (the decision tick).
- STR: if the majority is 1, it is a glitch; return to IDLE at the decision tick with no outputs. Otherwise move to DATA at tick PRESCALE-1.
- DATA: shift the majority value in at the MSB end at each decision tick (LSB-first reception). After bit DATA_WIDTH-1 reaches tick PRESCALE-1, go to PAR if the latched Par_en = 1, else STP.
- PAR: the expected parity is XOR(data) XOR Par_typ. A mismatch at the decision tick sets an internal parity-error flag. Move to STP at tick PRESCALE-1.
- STP: at the decision tick, return to IDLE immediately; the rest of the stop bit is treated as idle. Then, on the next cycle:
  - stop = 0: stp_err = 1.
  - parity flag set: par_err = 1.
  - no error: data_valid = 1 and P_DATA ← shift register.
  - Both stp_err and par_err may pulse together. data_valid never pulses with either error.
- P_DATA holds its value until the next good frame. An errored frame never alters it.
- Break condition (line held low): reported as stp_err, then the block waits in IDLE until a new 1→0 edge.
- Reset values:
  - P_DATA = 0, data_valid = 0, par_err = 0, stp_err = 0, busy = 0.
  - state = IDLE, both counters 0, latched parity configuration 0.
- rst asserted in any state: the frame is aborted and all of the above hold on the cycle after the rst edge. rst takes priority over all other events.

## Timing
- RX_IN edge to rx_s: 2 cycles. Start detection, cycle D, occurs 1 cycle after rx_s falls.
- Stop bit index S = 1 + DATA_WIDTH + Par_en.
- Result pulse (data_valid, par_err or stp_err) occurs at cycle D + S·PRESCALE + M + 2.
  - Defaults without parity: D + 78.
  - Defaults with parity: D + 86.
- Back-to-back frames: a start edge may arrive any time after the stop decision tick. Frame results are spaced exactly (S+1)·PRESCALE cycles apart; 80 cycles at defaults.
- busy rises at D+1 and falls on the cycle the result pulse is asserted. For a glitch, busy falls at D + M + 2.
- Par_en/Par_typ changes mid-frame have no effect on the current frame.
- Baud tolerance: the majority window must fall inside the bit. The required tolerance is ±3% at PRESCALE = 8.

## Test plan
- 0xA5, Par_en = 0, defaults: exactly one data_valid at D+78, P_DATA = 0xA5, par_err = stp_err = 0, busy high D+1..D+77.
- 0x3C, Par_en = 1, Par_typ = 0, parity bit 0: data_valid at D+86, P_DATA = 0x3C. Then 0x3C with Par_typ = 1 and parity bit 0: par_err pulse at D+86, no data_valid, P_DATA stays 0x3C.
- 0x55 with stop bit 0, line held low for 20 bit times: stp_err pulse, no data_valid, busy stays 0 while low. The next 1→0 edge starts a frame that receives 0x0F correctly.
- RX_IN low for 2 cycles: busy high for M+1 cycles, then IDLE, no output pulses. A single-cycle low during data bit 4 of 0xFF at tick M is voted out, and 0xFF is received.
- Back-to-back 0x01, 0xFF, 0x80 with stop bits exactly one bit long: three data_valid pulses exactly 80 cycles apart, with correct values.
- rst pulse during DATA bit 3 of 0x12: all outputs 0 and busy 0 on the next cycle, no pulses for the aborted frame. A following 0x81 frame gives data_valid with P_DATA = 0x81.
